// File: rtl/mmul_pkg.sv
// Shared definitions for the word-serial Montgomery multiplier: controller state
// codes, operand-select codes and counter-width helper.
package mmul_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StAdd   = 3'd1;
  localparam state_t StShift = 3'd2;
  localparam state_t StSub   = 3'd3;
  localparam state_t StDrain = 3'd4;

  localparam logic [1:0] LdA = 2'b00;
  localparam logic [1:0] LdB = 2'b01;
  localparam logic [1:0] LdP = 2'b10;

  // Counter width able to hold n_vals distinct values (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n_vals);
    return (n_vals <= 2) ? 1 : $clog2(n_vals);
  endfunction

endpackage

// File: rtl/mmul_core_param_if.sv
// Load / start / drain signal bundle of the Montgomery multiplier.
// master = operand loader / consumer side, slave = multiplier core.
interface mmul_core_param_if #(
  parameter int unsigned DW = 16
);
  logic          ld_en;
  logic [1:0]    ld_sel;
  logic [DW-1:0] din;
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;

  modport master (
    output ld_en, ld_sel, din, start, dout_ready,
    input  busy, done, err, dout, dout_valid
  );

  modport slave (
    input  ld_en, ld_sel, din, start, dout_ready,
    output busy, done, err, dout, dout_valid
  );
endinterface

// File: rtl/mmul_word_add3.sv
// DW-bit three-operand word adder with a 2-bit carry chain. In subtract mode it
// computes a_i - b_i - cin_i[0] and returns the borrow in cout_o[0].
module mmul_word_add3 #(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] c_i,
  input  logic [1:0]    cin_i,
  input  logic          sub_i,
  output logic [DW-1:0] sum_o,
  output logic [1:0]    cout_o
);

  logic [DW+1:0] sum;

  // Add: a+b+c+cin; subtract: a + ~b + !borrow, carry out means no borrow.
  always_comb begin
    if (sub_i) begin
      sum = {2'b00, a_i} + {2'b00, ~b_i} + {{(DW + 1){1'b0}}, ~cin_i[0]};
    end else begin
      sum = {2'b00, a_i} + {2'b00, b_i} + {2'b00, c_i} + {{DW{1'b0}}, cin_i};
    end
    sum_o  = sum[DW-1:0];
    cout_o = sub_i ? {1'b0, ~sum[DW]} : sum[DW+1:DW];
  end

endmodule

// File: rtl/mmul_core_param.sv
// Word-serial radix-2 Montgomery multiplier, R = A*B*2^-N mod P.
// Operand registers rotate by one word per datapath cycle so the shared adder
// always works on word 0; A rotates one bit per SHIFT. Everything returns to its
// loaded orientation at the end of a run, so operands can be reused.
// Requires W = N/DW >= 2.
// Optional feature: define MMUL_SKIP_ZERO_EN to skip the ADD pass for bits where
// A[i]==0 and C[0]==0 (data-dependent latency). Undefined: constant-time.
module mmul_core_param
  import mmul_pkg::*;
#(
  parameter int unsigned N  = 256,
  parameter int unsigned DW = 16
) (
  input logic               clk,
  input logic               rst_n,
  mmul_core_param_if.slave  bus
);

  localparam int unsigned W   = N / DW;
  localparam int unsigned BcW = cnt_width(N);
  localparam int unsigned WcW = cnt_width(W + 1);

  localparam logic [BcW-1:0] BitLast  = BcW'(N - 1);
  localparam logic [WcW-1:0] WordLast = WcW'(W - 1);
  localparam logic [WcW-1:0] WordSel  = WcW'(W);

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   p_q, p_d;
  logic [N+1:0]   c_q, c_d;
  logic [N-1:0]   r_q, r_d;
  logic [BcW-1:0] bit_cnt_q, bit_cnt_d;
  logic [WcW-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]     cy_q, cy_d;
  logic           q_q, q_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [DW-1:0]  add_b, add_c, add_s;
  logic [1:0]     add_cin, add_cout;
  logic           add_sub;
  logic           first_word;
  logic           q_eff;
  logic           use_d;
  logic           skip_now;

  mmul_word_add3 #(
    .DW (DW)
  ) u_add (
    .a_i    (c_q[DW-1:0]),
    .b_i    (add_b),
    .c_i    (add_c),
    .cin_i  (add_cin),
    .sub_i  (add_sub),
    .sum_o  (add_s),
    .cout_o (add_cout)
  );

`ifdef MMUL_SKIP_ZERO_EN
  // Skip decision for the bit about to start: from IDLE C is zero, from SHIFT the
  // next a and C[0] are the current bit 1 values.
  always_comb begin
    if (state_q == StIdle) begin
      skip_now = ~a_q[0];
    end else begin
      skip_now = ~a_q[1] & ~c_q[1];
    end
  end
`else
  assign skip_now = 1'b0;
`endif

  // Controller and word-serial datapath next state.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    p_d        = p_q;
    c_d        = c_q;
    r_d        = r_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    cy_d       = cy_q;
    q_d        = q_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    add_b      = '0;
    add_c      = '0;
    add_cin    = 2'b00;
    add_sub    = 1'b0;
    use_d      = 1'b0;
    first_word = (word_cnt_q == '0);
    // q is fixed by word 0 of the pass; later words see rotated C/B.
    q_eff      = first_word ? (c_q[0] ^ (a_q[0] & b_q[0])) : q_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (p_q[0]) begin
            c_d        = '0;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            state_d    = skip_now ? StShift : StAdd;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.ld_en) begin
          case (bus.ld_sel)
            LdA:     a_d = {bus.din, a_q[N-1:DW]};
            LdB:     b_d = {bus.din, b_q[N-1:DW]};
            LdP:     p_d = {bus.din, p_q[N-1:DW]};
            default: ;
          endcase
        end
      end

      StAdd: begin
        add_b   = a_q[0] ? b_q[DW-1:0] : '0;
        add_c   = q_eff ? p_q[DW-1:0] : '0;
        add_cin = first_word ? 2'b00 : cy_q;
        q_d     = q_eff;
        cy_d    = add_cout;
        b_d     = {b_q[DW-1:0], b_q[N-1:DW]};
        p_d     = {p_q[DW-1:0], p_q[N-1:DW]};
        c_d[N-1:0] = {add_s, c_q[N-1:DW]};
        if (word_cnt_q == WordLast) begin
          // C[N] can already be set (C < 2P), so accumulate rather than overwrite.
          c_d[N+1:N] = c_q[N+1:N] + add_cout;
          word_cnt_d = '0;
          state_d    = StShift;
        end else begin
          word_cnt_d = word_cnt_q + WcW'(1);
        end
      end

      StShift: begin
        c_d = c_q >> 1;
        a_d = {a_q[0], a_q[N-1:1]};
        if (bit_cnt_q == BitLast) begin
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = StSub;
        end else begin
          bit_cnt_d = bit_cnt_q + BcW'(1);
          state_d   = skip_now ? StShift : StAdd;
        end
      end

      StSub: begin
        if (word_cnt_q == WordSel) begin
          // Borrow of C - P is in cy_q[0]; keep C only if it was already below P.
          use_d      = (c_q[N+1:N] != 2'b00) || !cy_q[0];
          r_d        = use_d ? r_q : c_q[N-1:0];
          done_d     = 1'b1;
          word_cnt_d = '0;
          state_d    = StDrain;
        end else begin
          add_sub    = 1'b1;
          add_b      = p_q[DW-1:0];
          add_cin    = {1'b0, first_word ? 1'b0 : cy_q[0]};
          cy_d       = add_cout;
          p_d        = {p_q[DW-1:0], p_q[N-1:DW]};
          c_d[N-1:0] = {c_q[DW-1:0], c_q[N-1:DW]};
          r_d        = {add_s, r_q[N-1:DW]};
          word_cnt_d = word_cnt_q + WcW'(1);
        end
      end

      StDrain: begin
        if (bus.dout_ready) begin
          r_d = {r_q[DW-1:0], r_q[N-1:DW]};
          if (word_cnt_q == WordLast) begin
            word_cnt_d = '0;
            state_d    = StIdle;
          end else begin
            word_cnt_d = word_cnt_q + WcW'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any run and clears operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      c_q        <= '0;
      r_q        <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      cy_q       <= 2'b00;
      q_q        <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      p_q        <= p_d;
      c_q        <= c_d;
      r_q        <= r_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      cy_q       <= cy_d;
      q_q        <= q_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Outputs decoded from registered state; dout is forced to zero outside DRAIN.
  always_comb begin
    bus.busy       = (state_q != StIdle);
    bus.done       = done_q;
    bus.err        = err_q;
    bus.dout_valid = (state_q == StDrain);
    bus.dout       = (state_q == StDrain) ? r_q[DW-1:0] : '0;
  end

endmodule

// File: tb/tb_mmul_core_param.sv
// Bench for mmul_core_param (N=16, DW=8): directed scenarios plus random A,B,P
// runs checked against a modular-arithmetic reference model.
module tb_mmul_core_param;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 8;
`ifdef MMUL_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mmul_core_param_if #(.DW(DW)) bus ();

  mmul_core_param #(
    .N  (N),
    .DW (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_done_cyc = -1;
  int done_cyc = -1;
  int done_seen = 0;
  int accept_cyc = 0;
  logic [7:0] exp_words[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // A*B*2^-16 mod P: reduce the product, then halve 16 times modulo P.
  function automatic logic [15:0] mont_ref(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] p);
    longint unsigned x;
    x = (longint'(a) * longint'(b)) % longint'(p);
    for (int i = 0; i < 16; i++) begin
      if (x % 2 == 1) x = (x + longint'(p)) / 2;
      else            x = x / 2;
    end
    return x[15:0];
  endfunction

  // Cycles from accepted start to done, following the radix-2 recurrence.
  function automatic int lat_ref(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] p);
    longint unsigned c = 0;
    int lat = 0;
    for (int i = 0; i < 16; i++) begin
      bit ai;
      bit qi;
      ai = a[i];
      qi = c[0] ^ (ai & b[0]);
      if (SKIP && !ai && !c[0]) lat += 1;
      else                      lat += 3;
      c = (c + (ai ? longint'(b) : 0) + (qi ? longint'(p) : 0)) >> 1;
    end
    return lat + 3;
  endfunction

  // Output monitor: done timing and every presented result word.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.done === 1'b1 || (exp_done_cyc >= 0 && cyc == exp_done_cyc)) begin
        check("done_cycle", (bus.done === 1'b1) ? cyc : -1, exp_done_cyc);
        if (bus.done === 1'b1) begin
          done_seen++;
          done_cyc = cyc;
        end
        exp_done_cyc = -1;
      end
      if (bus.dout_valid !== 1'b0) begin
        if (exp_words.size() == 0) begin
          check("unexpected_dout_valid", bus.dout_valid, 0);
        end else begin
          check("dout_word", bus.dout, exp_words[0]);
          if (bus.dout_ready === 1'b1) void'(exp_words.pop_front());
        end
      end
    end
  end

  task automatic load_op(input logic [1:0] sel, input logic [15:0] v);
    for (int w = 0; w < 2; w++) begin
      bus.ld_en  = 1'b1;
      bus.ld_sel = sel;
      bus.din    = v[w*8 +: 8];
      @(posedge clk); #1;
    end
    bus.ld_en = 1'b0;
  endtask

  task automatic start_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] p);
    logic [15:0] r;
    r = mont_ref(a, b, p);
    exp_words.push_back(r[7:0]);
    exp_words.push_back(r[15:8]);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    accept_cyc   = cyc;
    exp_done_cyc = cyc + lat_ref(a, b, p);
    check("start_busy", bus.busy, 1);
  endtask

  task automatic wait_idle(input bit rnd_ready);
    int t = 0;
    while (bus.busy === 1'b1 && t < 300) begin
      bus.dout_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk); #1;
      t++;
    end
    bus.dout_ready = 1'b1;
    check("idle_timeout", bus.busy, 0);
    check("words_drained", exp_words.size(), 0);
  endtask

  initial begin
    logic [15:0] pa, pb, pp;
    int seen0;

    bus.ld_en      = 1'b0;
    bus.ld_sel     = 2'b00;
    bus.din        = '0;
    bus.start      = 1'b0;
    bus.dout_ready = 1'b1;
    rst_n          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_dout", bus.dout, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the reference model with hand-computed values.
    check("ref_basic", mont_ref(16'h000F, 16'h0005, 16'hFFF1), 16'h0005);
    check("ref_final_sub", mont_ref(16'hFFF0, 16'h000F, 16'hFFF1), 16'hFFF0);
    check("ref_zero", mont_ref(16'h0000, 16'h1234, 16'hFFF1), 16'h0000);
    check("ref_lat_zero", lat_ref(16'h0000, 16'h1234, 16'hFFF1), SKIP ? 19 : 51);

    // 1: basic, with a reserved-select load that must be ignored
    load_op(2'b10, 16'hFFF1);
    load_op(2'b00, 16'h000F);
    load_op(2'b01, 16'h0005);
    load_op(2'b11, 16'hFFFF);
    seen0 = done_seen;
    start_mul(16'h000F, 16'h0005, 16'hFFF1);
    wait_idle(1'b0);
    check("t1_done_count", done_seen - seen0, 1);
    check("t1_latency", done_cyc - accept_cyc, SKIP ? lat_ref(16'h000F, 16'h0005, 16'hFFF1) : 51);

    // 2: final subtract path
    load_op(2'b00, 16'hFFF0);
    load_op(2'b01, 16'h000F);
    start_mul(16'hFFF0, 16'h000F, 16'hFFF1);
    wait_idle(1'b1);

    // 3: even modulus
    load_op(2'b10, 16'hFFF0);
    seen0 = done_seen;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("t3_err_pulse", bus.err, 1);
    check("t3_busy", bus.busy, 0);
    @(posedge clk); #1;
    check("t3_err_clear", bus.err, 0);
    repeat (60) @(posedge clk);
    #1;
    check("t3_no_done", done_seen - seen0, 0);
    check("t3_still_idle", bus.busy, 0);
    load_op(2'b10, 16'hFFF1);

    // 4: backpressure; loads and start during DRAIN ignored
    load_op(2'b00, 16'h000F);
    load_op(2'b01, 16'h0005);
    bus.dout_ready = 1'b0;
    start_mul(16'h000F, 16'h0005, 16'hFFF1);
    for (int t = 0; t < 200 && bus.dout_valid !== 1'b1; t++) begin
      @(posedge clk); #1;
    end
    check("t4_valid_seen", bus.dout_valid, 1);
    for (int k = 0; k < 5; k++) begin
      bus.ld_en  = 1'b1;
      bus.ld_sel = 2'b00;
      bus.din    = 8'hAA;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      check("t4_hold_dout", bus.dout, 8'h05);
      check("t4_hold_valid", bus.dout_valid, 1);
      check("t4_hold_busy", bus.busy, 1);
    end
    bus.ld_en      = 1'b0;
    bus.start      = 1'b0;
    bus.dout_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_word1", bus.dout, 8'h00);
    check("t4_busy_mid", bus.busy, 1);
    @(posedge clk); #1;
    check("t4_idle", bus.busy, 0);
    check("t4_drained", exp_words.size(), 0);
    // Operands must be intact after the ignored loads.
    start_mul(16'h000F, 16'h0005, 16'hFFF1);
    wait_idle(1'b0);

    // 5: reset in the middle of the iteration
    start_mul(16'h000F, 16'h0005, 16'hFFF1);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_busy", bus.busy, 0);
    check("t5_done", bus.done, 0);
    check("t5_err", bus.err, 0);
    check("t5_dout_valid", bus.dout_valid, 0);
    check("t5_dout", bus.dout, 0);
    exp_words.delete();
    exp_done_cyc = -1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_op(2'b10, 16'hFFF1);
    load_op(2'b00, 16'h000F);
    load_op(2'b01, 16'h0005);
    start_mul(16'h000F, 16'h0005, 16'hFFF1);
    wait_idle(1'b0);

    // 6: zero multiplier
    load_op(2'b00, 16'h0000);
    load_op(2'b01, 16'h1234);
    start_mul(16'h0000, 16'h1234, 16'hFFF1);
    wait_idle(1'b0);
    check("t6_latency", done_cyc - accept_cyc, SKIP ? 19 : 51);

    // Random operands against the reference model
    pp = 16'hFFF1;
    for (int r = 0; r < 600; r++) begin
      if (r % 60 == 30) begin
        pp = 16'($urandom_range(3, 65535)) | 16'h0001;
        load_op(2'b10, pp);
      end
      pa = 16'($urandom_range(0, int'(pp) - 1));
      pb = 16'($urandom_range(0, int'(pp) - 1));
      load_op(2'b00, pa);
      load_op(2'b01, pb);
      start_mul(pa, pb, pp);
      wait_idle(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
